// File: rtl/arm_pkg.sv
// Shared ARM core definitions: datapath widths, the PC register index and
// the multiply unit state encoding.
package arm_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int PC_INDEX   = 15;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_MUL  = 2'd1,
        MUL_WB   = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// Radix-2 iterative shift-add multiplier for MUL/MLA with register-file
// writeback and optional N/Z update. Define MUL_EARLY_TERM_EN to stop once no multiplier bits remain.
module mul_unit
    import arm_pkg::mul_state_e;
    import arm_pkg::MUL_IDLE;
    import arm_pkg::MUL_MUL;
    import arm_pkg::MUL_WB;
#(
    parameter int WORD_SIZE  = arm_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = arm_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  accumulate,
    input  logic                  set_flags,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic [WORD_SIZE-1:0]  op_m,
    input  logic [WORD_SIZE-1:0]  op_s,
    input  logic [WORD_SIZE-1:0]  op_acc,
    output logic                  busy,
    output logic                  rd_we,
    output logic [WORD_SIZE-1:0]  rd_out,
    output logic [ADDR_WIDTH-1:0] write_rd,
    output logic                  cpsr_nz_we,
    output logic [1:0]            cpsr_nz
);

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(arm_pkg::PC_INDEX);

    mul_state_e             state_reg;
    logic [WORD_SIZE-1:0]   prod_reg;
    logic [WORD_SIZE-1:0]   mcand_reg;
    logic [WORD_SIZE-1:0]   mplier_reg;
    logic [4:0]             iter_reg;
    logic [ADDR_WIDTH-1:0]  dest_reg;
    logic                   set_flags_reg;
    logic                   busy_reg;
    logic                   rd_we_reg;
    logic [WORD_SIZE-1:0]   rd_out_reg;
    logic [ADDR_WIDTH-1:0]  write_rd_reg;
    logic                   cpsr_nz_we_reg;
    logic [1:0]             cpsr_nz_reg;

    logic [WORD_SIZE-1:0]   prod_next;
    logic [WORD_SIZE-1:0]   mplier_next;
    logic                   last_step;

    always_comb begin
        prod_next   = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
        mplier_next = mplier_reg >> 1;
`ifdef MUL_EARLY_TERM_EN
        last_step   = (mplier_next == '0) || (iter_reg == 5'd31);
`else
        last_step   = (iter_reg == 5'd31);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= MUL_IDLE;
            prod_reg       <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            iter_reg       <= '0;
            dest_reg       <= '0;
            set_flags_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            rd_we_reg      <= 1'b0;
            rd_out_reg     <= '0;
            write_rd_reg   <= '0;
            cpsr_nz_we_reg <= 1'b0;
            cpsr_nz_reg    <= 2'b00;
        end else begin
            rd_we_reg      <= 1'b0;
            cpsr_nz_we_reg <= 1'b0;
            case (state_reg)
                MUL_IDLE: begin
                    if (start) begin
                        prod_reg      <= accumulate ? op_acc : '0;
                        mcand_reg     <= op_m;
                        mplier_reg    <= op_s;
                        iter_reg      <= '0;
                        dest_reg      <= dest;
                        set_flags_reg <= set_flags;
                        busy_reg      <= 1'b1;
                        state_reg     <= MUL_MUL;
                    end
                end
                MUL_MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_next;
                    iter_reg   <= iter_reg + 5'd1;
                    if (last_step) begin
                        // Outputs are registered here so they are valid throughout the WB cycle.
                        state_reg      <= MUL_WB;
                        rd_out_reg     <= prod_next;
                        write_rd_reg   <= dest_reg;
                        rd_we_reg      <= (dest_reg != PC_ADDR);
                        cpsr_nz_we_reg <= set_flags_reg;
                        cpsr_nz_reg    <= {prod_next[WORD_SIZE-1], (prod_next == '0)};
                    end
                end
                MUL_WB: begin
                    busy_reg  <= 1'b0;
                    state_reg <= MUL_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign rd_we      = rd_we_reg;
    assign rd_out     = rd_out_reg;
    assign write_rd   = write_rd_reg;
    assign cpsr_nz_we = cpsr_nz_we_reg;
    assign cpsr_nz    = cpsr_nz_reg;

endmodule
